// File: rtl/tmds_channel_decoder.sv
// Receive-side decoder for one TMDS channel: finds symbol alignment on control-token runs,
// then decodes video bytes and control tokens from unaligned 10-bit deserializer words.
module tmds_channel_decoder #(
  parameter int unsigned CTRL_RUN       = 32,
  parameter int unsigned SEARCH_TIMEOUT = 2048,
  parameter int unsigned LOSS_TIMEOUT   = 2048
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic [9:0] i_sym,
  output logic [7:0] o_data,
  output logic       o_de,
  output logic [1:0] o_ctrl,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int unsigned MAX_TMO = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_TMO + 1);

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(CTRL_RUN - 1);
  localparam logic [CNT_W-1:0] SRCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_TIMEOUT - 1);
  localparam logic [1:0]       GUARD_SYMS = 2'd2;
  localparam logic [3:0]       OFFSET_MAX = 4'd9;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  typedef enum logic {S_SEARCH = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [9:0]       r_r0;
  logic [9:0]       r_r1;
  logic [9:0]       r_a_sym;
  logic [19:0]      w_window;
  logic [3:0]       r_offset;
  logic [3:0]       w_offset_next;
  logic [3:0]       w_offset_inc;
  logic [CNT_W-1:0] r_run;
  logic [CNT_W-1:0] w_run_next;
  logic [CNT_W-1:0] r_tmo;
  logic [CNT_W-1:0] w_tmo_next;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] w_gap_next;
  logic [1:0]       r_guard;
  logic [1:0]       w_guard_next;
  logic             w_is_tok;
  logic [1:0]       w_tok_val;
  logic [7:0]       w_d;
  logic [7:0]       w_dec;
  logic [7:0]       r_data;
  logic [7:0]       w_data_next;
  logic             r_de;
  logic             w_de_next;
  logic [1:0]       r_ctrl;
  logic [1:0]       w_ctrl_next;
  logic             r_locked;
  logic             w_locked_next;

  // Bit-slip window: older word in the low half, so bit 0 is the earliest serial bit
  assign w_window     = {r_r0, r_r1};
  assign w_offset_inc = (r_offset == OFFSET_MAX) ? 4'd0 : r_offset + 4'd1;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_r0    <= '0;
      r_r1    <= '0;
      r_a_sym <= '0;
    end else begin
      r_r0    <= i_sym;
      r_r1    <= r_r0;
      r_a_sym <= w_window[r_offset +: 10];
    end
  end

  always_comb begin
    w_is_tok  = 1'b1;
    w_tok_val = 2'b00;
    case (r_a_sym)
      TOK_C00: w_tok_val = 2'b00;
      TOK_C01: w_tok_val = 2'b01;
      TOK_C10: w_tok_val = 2'b10;
      TOK_C11: w_tok_val = 2'b11;
      default: w_is_tok  = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition-minimising chain
  always_comb begin
    w_d      = r_a_sym[9] ? ~r_a_sym[7:0] : r_a_sym[7:0];
    w_dec    = '0;
    w_dec[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_dec[i] = r_a_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_state  <= S_SEARCH;
      r_offset <= '0;
      r_run    <= '0;
      r_tmo    <= '0;
      r_gap    <= '0;
      r_guard  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_offset <= w_offset_next;
      r_run    <= w_run_next;
      r_tmo    <= w_tmo_next;
      r_gap    <= w_gap_next;
      r_guard  <= w_guard_next;
    end
  end

  // Symbols straddling an offset change are stale, so the guard keeps them out of the run
  always_comb begin
    w_state_next  = r_state;
    w_offset_next = r_offset;
    w_run_next    = r_run;
    w_tmo_next    = r_tmo;
    w_gap_next    = r_gap;
    w_guard_next  = r_guard;
    case (r_state)
      S_SEARCH: begin
        w_tmo_next = r_tmo + CNT_W'(1);
        if (r_guard != 2'd0) begin
          w_guard_next = r_guard - 2'd1;
          w_run_next   = '0;
        end else if (w_is_tok) begin
          w_run_next = r_run + CNT_W'(1);
        end else begin
          w_run_next = '0;
        end
        if ((r_guard == 2'd0) && w_is_tok && (r_run == RUN_LAST)) begin
          w_state_next = S_LOCKED;
          w_run_next   = '0;
          w_tmo_next   = '0;
          w_gap_next   = '0;
        end else if (r_tmo == SRCH_LAST) begin
          w_offset_next = w_offset_inc;
          w_run_next    = '0;
          w_tmo_next    = '0;
          w_guard_next  = GUARD_SYMS;
        end
      end
      S_LOCKED: begin
        if (w_is_tok) begin
          w_gap_next = '0;
        end else if (r_gap == LOSS_LAST) begin
          w_state_next  = S_SEARCH;
          w_offset_next = w_offset_inc;
          w_run_next    = '0;
          w_tmo_next    = '0;
          w_gap_next    = '0;
          w_guard_next  = GUARD_SYMS;
        end else begin
          w_gap_next = r_gap + CNT_W'(1);
        end
      end
      default: w_state_next = S_SEARCH;
    endcase
  end

  // Outputs follow the lock state being entered, so o_locked and o_de/o_ctrl stay consistent
  always_comb begin
    w_locked_next = (w_state_next == S_LOCKED);
    w_de_next     = 1'b0;
    w_data_next   = '0;
    w_ctrl_next   = '0;
    if (w_locked_next) begin
      if (w_is_tok) begin
        w_ctrl_next = w_tok_val;
      end else begin
        w_de_next   = 1'b1;
        w_data_next = w_dec;
        w_ctrl_next = r_ctrl;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_locked <= 1'b0;
      r_de     <= 1'b0;
      r_data   <= '0;
      r_ctrl   <= '0;
    end else begin
      r_locked <= w_locked_next;
      r_de     <= w_de_next;
      r_data   <= w_data_next;
      r_ctrl   <= w_ctrl_next;
    end
  end

  assign o_data   = r_data;
  assign o_de     = r_de;
  assign o_ctrl   = r_ctrl;
  assign o_locked = r_locked;
  assign o_offset = r_offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: lock, decode, bit-slip search, lock loss and reset.
module tb_tmds_channel_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T11 = 10'b1010101011;

  logic       clk_25mhz = 1'b0;
  logic       reset;
  logic [9:0] i_sym;
  logic [7:0] o_data;
  logic       o_de;
  logic [1:0] o_ctrl;
  logic       o_locked;
  logic [3:0] o_offset;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         t       = 0;
  int         delay   = 0;
  logic [9:0] prev_sym;
  logic [7:0] hist_b [4];

  always #20 clk_25mhz = ~clk_25mhz;

  tmds_channel_decoder dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .i_sym     (i_sym),
    .o_data    (o_data),
    .o_de      (o_de),
    .o_ctrl    (o_ctrl),
    .o_locked  (o_locked),
    .o_offset  (o_offset)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step(input logic [9:0] w);
    i_sym = w;
    @(posedge clk_25mhz);
    #1;
    t++;
  endtask

  // Serial stream delayed by 'delay' bits: tail of the previous symbol fills the low bits
  task automatic send(input logic [9:0] sym, input logic [7:0] b);
    logic [19:0] cat;
    cat      = {sym, prev_sym};
    prev_sym = sym;
    for (int i = 3; i > 0; i--) hist_b[i] = hist_b[i-1];
    hist_b[0] = b;
    step(10'(cat >> (10 - delay)));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(T00);
    reset = 1'b0;
    t = 0;
  endtask

  function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic inv);
    int         ones;
    logic [8:0] qm;
    ones  = $countones(d);
    qm    = '0;
    qm[0] = d[0];
    if (ones > 4 || (ones == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  initial begin
    logic [7:0] b;
    logic       inv;
    logic       tok;
    reset    = 1'b1;
    i_sym    = '0;
    prev_sym = '0;
    for (int i = 0; i < 4; i++) hist_b[i] = '0;
    step(10'h0);

    // Reset state and lock on a 40-token run at offset 0
    do_reset();
    chk("rst_locked", 16'(o_locked), 16'h0);
    chk("rst_offset", 16'(o_offset), 16'h0);
    chk("rst_de",     16'(o_de),     16'h0);
    chk("rst_data",   16'(o_data),   16'h0);
    chk("rst_ctrl",   16'(o_ctrl),   16'h0);
    for (int k = 1; k <= 40; k++) begin
      send(T00, 8'h00);
      if (t == 34) chk("t1_not_yet_locked", 16'(o_locked), 16'h0);
      if (t == 35) chk("t1_locked", 16'(o_locked), 16'h1);
    end
    chk("t1_offset", 16'(o_offset), 16'h0);
    chk("t1_ctrl",   16'(o_ctrl),   16'h0);
    chk("t1_de",     16'(o_de),     16'h0);

    // Hand-decoded data words; o_ctrl must hold the preceding token value
    for (int k = 0; k < 4; k++) send(T11, 8'h00);
    send(10'h100, 8'h00);
    send(10'h2FF, 8'hFE);
    send(T01, 8'h00);
    chk("t2_ctrl_tok11", 16'(o_ctrl), 16'h3);
    send(T01, 8'h00);
    chk("t2_de_a",   16'(o_de),   16'h1);
    chk("t2_data_a", 16'(o_data), 16'h00);
    chk("t2_ctrl_a", 16'(o_ctrl), 16'h3);
    send(T01, 8'h00);
    chk("t2_de_b",   16'(o_de),   16'h1);
    chk("t2_data_b", 16'(o_data), 16'hFE);
    chk("t2_ctrl_b", 16'(o_ctrl), 16'h3);
    send(T01, 8'h00);
    chk("t2_de_c",   16'(o_de),   16'h0);
    chk("t2_data_c", 16'(o_data), 16'h00);
    chk("t2_ctrl_c", 16'(o_ctrl), 16'h1);

    // One-cycle reset while locked, then a fresh 32-token run is needed
    do_reset();
    chk("t5_locked", 16'(o_locked), 16'h0);
    chk("t5_offset", 16'(o_offset), 16'h0);
    chk("t5_de",     16'(o_de),     16'h0);
    chk("t5_ctrl",   16'(o_ctrl),   16'h0);
    for (int k = 1; k <= 35; k++) begin
      send(T00, 8'h00);
      if (t == 34) chk("t5_not_yet_locked", 16'(o_locked), 16'h0);
    end
    chk("t5_relocked", 16'(o_locked), 16'h1);

    // Token run completes on the very cycle the search timeout fires
    do_reset();
    for (int k = 1; k <= 2013; k++) send(10'h100, 8'h00);
    for (int k = 2014; k <= 2049; k++) begin
      send(T00, 8'h00);
      if (t == 2047) chk("t6_not_yet_locked", 16'(o_locked), 16'h0);
      if (t == 2048) begin
        chk("t6_locked", 16'(o_locked), 16'h1);
        chk("t6_offset", 16'(o_offset), 16'h0);
      end
    end
    chk("t6_offset_after", 16'(o_offset), 16'h0);

    // 3-bit delayed stream with 800-cycle lines; then loss, search to 9, relock, loss wraps to 0
    do_reset();
    delay    = 3;
    prev_sym = '0;
    for (int s = 1; s <= 21010; s++) begin
      delay = (s <= 18851) ? 3 : 9;
      tok   = (s <= 6560 && ((s - 1) % 800) < 160) || (s >= 18852 && s <= 18951);
      if (tok) begin
        send(T00, 8'h00);
      end else if (s > 18840 && s <= 18851) begin
        send(tmds_enc(8'h00, 1'b0), 8'h00);
      end else begin
        b   = 8'($urandom);
        inv = 1'($urandom);
        send(tmds_enc(b, inv), b);
      end
      if (s == 2047)  chk("t3_offset_pre_step", 16'(o_offset), 16'h0);
      if (s == 2048)  chk("t3_offset_step1",    16'(o_offset), 16'h1);
      if (s == 6143)  chk("t3_offset_2",        16'(o_offset), 16'h2);
      if (s == 6144)  chk("t3_offset_3",        16'(o_offset), 16'h3);
      if (s == 6200)  chk("t3_unlocked_wait",   16'(o_locked), 16'h0);
      if (s == 6500) begin
        chk("t3_locked",        16'(o_locked), 16'h1);
        chk("t3_locked_offset", 16'(o_offset), 16'h3);
      end
      if (s >= 6564 && s <= 6603) begin
        chk("t3_de",   16'(o_de),   16'h1);
        chk("t3_data", 16'(o_data), 16'(hist_b[3]));
      end
      if (s == 8610)  chk("t4_still_locked", 16'(o_locked), 16'h1);
      if (s == 8611) begin
        chk("t4_lock_lost",  16'(o_locked), 16'h0);
        chk("t4_offset_inc", 16'(o_offset), 16'h4);
      end
      if (s == 18850) chk("t4_offset_8", 16'(o_offset), 16'h8);
      if (s == 18851) chk("t4_offset_9", 16'(o_offset), 16'h9);
      if (s == 18885) chk("t4_not_yet_locked9", 16'(o_locked), 16'h0);
      if (s == 18886) begin
        chk("t4_locked9",        16'(o_locked), 16'h1);
        chk("t4_locked9_offset", 16'(o_offset), 16'h9);
      end
      if (s == 21001) chk("t4_still_locked9", 16'(o_locked), 16'h1);
      if (s == 21002) begin
        chk("t4_lock_lost9", 16'(o_locked), 16'h0);
        chk("t4_offset_wrap", 16'(o_offset), 16'h0);
        chk("t4_de_unlocked", 16'(o_de), 16'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
